// File: rtl/scan_chain_mock_pkg.sv
// Shared constants for the configuration scan chain: default chain length and
// shift-counter width, plus the saturating counter step.
package scan_chain_mock_pkg;

    localparam int unsigned SC_LENGTH_DEFAULT = 10;
    localparam int unsigned SC_CNT_W          = 16;

    localparam logic [SC_CNT_W-1:0] SC_CNT_MAX = {SC_CNT_W{1'b1}};

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [SC_CNT_W-1:0] sc_cnt_inc(input logic [SC_CNT_W-1:0] cnt);
        logic [SC_CNT_W-1:0] nxt;
        nxt = cnt;
        if (cnt != SC_CNT_MAX) begin
            nxt = cnt + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/scan_chain_mock.sv
// Serial configuration scan chain on the PMU test clock: shifts one bit per
// enabled edge, exposes the chain in parallel, and counts shifts (saturating).
module scan_chain_mock
    import scan_chain_mock_pkg::*;
#(
    parameter int unsigned LENGTH = SC_LENGTH_DEFAULT
) (
    input  logic                pmu_tck_in,
    input  logic                clear,
    input  logic                sc_en,
    input  logic                sc_data_in,
    output logic                sc_data_out,
    output logic [LENGTH-1:0]   sc_q,
    output logic [SC_CNT_W-1:0] sc_shift_cnt
);

    logic [LENGTH-1:0]   chain_q, chain_d;
    logic [SC_CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        chain_d = chain_q;
        cnt_d   = cnt_q;
        if (sc_en) begin
            chain_d = {chain_q[LENGTH-2:0], sc_data_in};
            cnt_d   = sc_cnt_inc(cnt_q);
        end
    end

    // clear wins over sc_en: the chain is wiped and no shift happens that edge.
    always_ff @(posedge pmu_tck_in) begin
        if (clear) begin
            chain_q <= '0;
            cnt_q   <= '0;
        end else begin
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sc_data_out  = chain_q[LENGTH-1];
    assign sc_q         = chain_q;
    assign sc_shift_cnt = cnt_q;

endmodule

// File: tb/tb_scan_chain_mock.sv
// Self-checking bench for scan_chain_mock: directed scenarios plus randomized
// traffic against a queue-based model of the shifted bit history.
module tb_scan_chain_mock;
    import scan_chain_mock_pkg::*;

    localparam int unsigned L  = 10;
    localparam int unsigned L4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          clear, sc_en, sc_data_in, sc_data_out;
    logic [L-1:0]  sc_q;
    logic [15:0]   sc_shift_cnt;

    logic          clear_4, sc_en_4, sc_data_in_4, sc_data_out_4;
    logic [L4-1:0] sc_q_4;
    logic [15:0]   sc_shift_cnt_4;

    scan_chain_mock #(.LENGTH(L)) dut (
        .pmu_tck_in   (clk),
        .clear        (clear),
        .sc_en        (sc_en),
        .sc_data_in   (sc_data_in),
        .sc_data_out  (sc_data_out),
        .sc_q         (sc_q),
        .sc_shift_cnt (sc_shift_cnt)
    );

    scan_chain_mock #(.LENGTH(L4)) dut4 (
        .pmu_tck_in   (clk),
        .clear        (clear_4),
        .sc_en        (sc_en_4),
        .sc_data_in   (sc_data_in_4),
        .sc_data_out  (sc_data_out_4),
        .sc_q         (sc_q_4),
        .sc_shift_cnt (sc_shift_cnt_4)
    );

    int checks = 0;
    int errors = 0;

    // Model: hist[k] is the bit shifted in k shifts ago (newest at index 0).
    bit hist[$];
    int mcnt;
    bit hist4[$];
    int mcnt4;

    function automatic logic [L-1:0] exp_q();
        logic [L-1:0] v = '0;
        for (int i = 0; i < hist.size(); i++) v[i] = hist[i];
        return v;
    endfunction

    function automatic logic exp_out();
        return (hist.size() >= L) ? hist[L-1] : 1'b0;
    endfunction

    function automatic logic [L4-1:0] exp_q4();
        logic [L4-1:0] v = '0;
        for (int i = 0; i < hist4.size(); i++) v[i] = hist4[i];
        return v;
    endfunction

    // Drive one cycle on the 10-cell chain; inputs change and outputs are read on negedges.
    task automatic cycle(input logic clr, input logic en, input logic din);
        clear      = clr;
        sc_en      = en;
        sc_data_in = din;
        @(posedge clk);
        if (clr) begin
            hist.delete();
            mcnt = 0;
        end else if (en) begin
            hist.push_front(din);
            if (hist.size() > L) void'(hist.pop_back());
            if (mcnt < 65535) mcnt++;
        end
        @(negedge clk);
    endtask

    task automatic cycle4(input logic clr, input logic en, input logic din);
        clear_4      = clr;
        sc_en_4      = en;
        sc_data_in_4 = din;
        @(posedge clk);
        if (clr) begin
            hist4.delete();
            mcnt4 = 0;
        end else if (en) begin
            hist4.push_front(din);
            if (hist4.size() > L4) void'(hist4.pop_back());
            if (mcnt4 < 65535) mcnt4++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_4 = 1'b1; sc_en_4 = 1'b1; sc_data_in_4 = 1'b1;
        cycle(1'b1, 1'($urandom), 1'($urandom));
        clear_4 = 1'b0; sc_en_4 = 1'b0;
        hist4.delete(); mcnt4 = 0;
        checks++;
        if (sc_q !== '0) begin errors++; $display("FAIL reset_q: got %h expected 0", sc_q); end
        checks++;
        if (sc_data_out !== 1'b0) begin
            errors++; $display("FAIL reset_out: got %b expected 0", sc_data_out);
        end
        checks++;
        if (sc_shift_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d expected 0", sc_shift_cnt);
        end
        checks++;
        if (sc_q_4 !== '0 || sc_shift_cnt_4 !== 16'd0) begin
            errors++; $display("FAIL reset4: got q=%h cnt=%0d expected 0", sc_q_4, sc_shift_cnt_4);
        end
    endtask

    task automatic test_shift_in();
        logic [L-1:0] pat = 10'b1011011011;
        for (int i = 0; i < L; i++) cycle(1'b0, 1'b1, pat[i]);
        checks++;
        if (sc_q !== 10'b1101101101) begin
            errors++; $display("FAIL shift_in_q: got %b expected 1101101101", sc_q);
        end
        checks++;
        if (sc_data_out !== 1'b1) begin
            errors++; $display("FAIL shift_in_out: got %b expected 1", sc_data_out);
        end
        checks++;
        if (sc_shift_cnt !== 16'd10) begin
            errors++; $display("FAIL shift_in_cnt: got %0d expected 10", sc_shift_cnt);
        end
    endtask

    task automatic test_hold();
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (sc_q !== 10'b1101101101 || sc_shift_cnt !== 16'd10) begin
            errors++;
            $display("FAIL hold: got q=%b cnt=%0d expected q=1101101101 cnt=10", sc_q, sc_shift_cnt);
        end
    endtask

    task automatic test_shift_out();
        logic [L-1:0] seq = 10'b0101101101; // seq[k] is the expected out after edge k+1
        checks++;
        if (sc_data_out !== 1'b1) begin
            errors++; $display("FAIL shift_out_pre: got %b expected 1", sc_data_out);
        end
        for (int k = 0; k < L; k++) begin
            cycle(1'b0, 1'b1, 1'b0);
            checks++;
            if (sc_data_out !== seq[k]) begin
                errors++; $display("FAIL shift_out_%0d: got %b expected %b", k, sc_data_out, seq[k]);
            end
        end
        checks++;
        if (sc_q !== '0 || sc_shift_cnt !== 16'd20) begin
            errors++; $display("FAIL shift_out_end: got q=%h cnt=%0d expected q=0 cnt=20",
                               sc_q, sc_shift_cnt);
        end
    endtask

    task automatic test_clear_mid();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1);
        checks++;
        if (sc_q !== 10'b0000011111) begin
            errors++; $display("FAIL clear_mid_pre: got %b expected 0000011111", sc_q);
        end
        cycle(1'b1, 1'b1, 1'b1);
        checks++;
        if (sc_q !== '0 || sc_shift_cnt !== 16'd0) begin
            errors++; $display("FAIL clear_mid: got q=%h cnt=%0d expected 0", sc_q, sc_shift_cnt);
        end
    endtask

    task automatic test_clear_priority();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b1);
            checks++;
            if (sc_q !== '0 || sc_shift_cnt !== 16'd0 || sc_data_out !== 1'b0) begin
                errors++; $display("FAIL clear_prio_%0d: got q=%h cnt=%0d expected 0",
                                   i, sc_q, sc_shift_cnt);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic clr, en, din;
            clr = ($urandom_range(99) < 3);
            en  = ($urandom_range(99) < 70);
            din = 1'($urandom);
            cycle(clr, en, din);
            checks++;
            if (sc_q !== exp_q() || sc_data_out !== exp_out()
                || sc_shift_cnt !== 16'(mcnt)) begin
                errors++;
                $display("FAIL random_%0d: got q=%b out=%b cnt=%0d expected q=%b out=%b cnt=%0d",
                         i, sc_q, sc_data_out, sc_shift_cnt, exp_q(), exp_out(), mcnt);
            end
        end
    endtask

    task automatic test_freeze_resume();
        logic [L-1:0] frozen;
        int           cnt_frozen;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'($urandom));
        frozen     = exp_q();
        cnt_frozen = mcnt;
        for (int i = 0; i < 25; i++) cycle(1'b0, 1'b0, 1'($urandom));
        checks++;
        if (sc_q !== frozen || sc_shift_cnt !== 16'(cnt_frozen)) begin
            errors++; $display("FAIL freeze: got q=%b cnt=%0d expected q=%b cnt=%0d",
                               sc_q, sc_shift_cnt, frozen, cnt_frozen);
        end
        cycle(1'b0, 1'b1, 1'b1);
        checks++;
        if (sc_q !== {frozen[L-2:0], 1'b1} || sc_shift_cnt !== 16'(cnt_frozen + 1)) begin
            errors++; $display("FAIL resume: got q=%b cnt=%0d expected q=%b cnt=%0d",
                               sc_q, sc_shift_cnt, {frozen[L-2:0], 1'b1}, cnt_frozen + 1);
        end
    endtask

    task automatic test_saturation();
        cycle4(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) begin
            cycle4(1'b0, 1'b1, 1'($urandom));
            if (i == 65533 || i == 65534 || i == 65535) begin
                checks++;
                if (sc_shift_cnt_4 !== 16'(mcnt4)) begin
                    errors++; $display("FAIL sat_cnt_%0d: got %h expected %h",
                                       i, sc_shift_cnt_4, 16'(mcnt4));
                end
            end
        end
        checks++;
        if (sc_shift_cnt_4 !== 16'hFFFF) begin
            errors++; $display("FAIL sat_final: got %h expected ffff", sc_shift_cnt_4);
        end
        for (int i = 0; i < 8; i++) begin
            cycle4(1'b0, 1'b1, 1'($urandom));
            checks++;
            if (sc_q_4 !== exp_q4() || sc_data_out_4 !== hist4[L4-1]) begin
                errors++; $display("FAIL sat_shift_%0d: got q=%b out=%b expected q=%b out=%b",
                                   i, sc_q_4, sc_data_out_4, exp_q4(), hist4[L4-1]);
            end
        end
    endtask

    initial begin
        clear = 1'b0; sc_en = 1'b0; sc_data_in = 1'b0;
        clear_4 = 1'b0; sc_en_4 = 1'b0; sc_data_in_4 = 1'b0;
        mcnt = 0; mcnt4 = 0;
        @(negedge clk);
        test_reset();
        test_shift_in();
        test_hold();
        test_shift_out();
        test_clear_mid();
        test_clear_priority();
        test_random();
        test_freeze_resume();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
